// File: rtl/reg_fifo_pkg.sv
// rtl/reg_fifo_pkg.sv - register map, bit positions and STATUS layout for reg_fifo_bank
package reg_fifo_pkg;

  localparam int REG_STATUS   = 0;
  localparam int REG_CTRL     = 1;
  localparam int REG_TXDATA   = 2;
  localparam int REG_RXDATA   = 3;
  localparam int REG_IRQ_MASK = 4;

  localparam int ST_TX_OVF   = 12;
  localparam int ST_RX_UDF   = 13;
  localparam int ST_TX_FULL  = 28;
  localparam int ST_TX_EMPTY = 29;
  localparam int ST_RX_FULL  = 30;
  localparam int ST_RX_EMPTY = 31;

  localparam int CTRL_TX_FLUSH = 0;
  localparam int CTRL_RX_FLUSH = 1;

  localparam int IRQ_TX_EMPTY    = 0;
  localparam int IRQ_RX_NONEMPTY = 1;
  localparam int IRQ_ERROR       = 2;

  typedef struct packed {
    logic       rx_empty;
    logic       rx_full;
    logic       tx_empty;
    logic       tx_full;
    logic [2:0] rsv_27_25;
    logic [8:0] rx_count;
    logic [1:0] rsv_15_14;
    logic       rx_udf;
    logic       tx_ovf;
    logic [2:0] rsv_11_9;
    logic [8:0] tx_count;
  } status_t;

endpackage

// File: rtl/reg_fifo_bank_if.sv
// rtl/reg_fifo_bank_if.sv - reg_ifc register access bundle with master/slave modports
interface reg_ifc #(parameter int AW = 4);
  logic          rd;
  logic [AW-1:0] raddr;
  logic [31:0]   rdata;
  logic          wr;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  modport master (output rd, raddr, wr, waddr, wdata, input rdata);
  modport slave  (input rd, raddr, wr, waddr, wdata, output rdata);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with flush and async reset
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] wptr, rptr;
  logic [IW:0]   cnt;
  logic          do_push, do_pop;

  // Flush dominates any same-cycle push or pop.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  assign full  = (cnt == (IW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + IW'(1);
      if (do_pop)  rptr <= rptr + IW'(1);
      if (do_push && !do_pop)      cnt <= cnt + (IW+1)'(1);
      else if (do_pop && !do_push) cnt <= cnt - (IW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/reg_fifo_bank.sv
// rtl/reg_fifo_bank.sv - register bank with TX/RX FIFOs and status/control registers
// Optional IRQ_MASK register and interrupt output under REG_FIFO_BANK_IRQ_EN.
module reg_fifo_bank
  import reg_fifo_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_ifc.slave         regs,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_status, wr_ctrl, wr_txdata, rd_rxdata;
  logic          tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [DW-1:0] rx_head;
  logic          tx_ovf, rx_udf;
  status_t       st;
  logic [31:0]   rdata_nxt;
  logic [31:0]   rx_head_ext;

  assign wr_status = regs.wr && (regs.waddr == AW'(REG_STATUS));
  assign wr_ctrl   = regs.wr && (regs.waddr == AW'(REG_CTRL));
  assign wr_txdata = regs.wr && (regs.waddr == AW'(REG_TXDATA));
  assign rd_rxdata = regs.rd && (regs.raddr == AW'(REG_RXDATA));

  // A TX pop in the same cycle does not free a slot for a register write.
  assign tx_push  = wr_txdata & ~tx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_flush = wr_ctrl & regs.wdata[CTRL_TX_FLUSH];
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd_rxdata & ~rx_empty;
  assign rx_flush = wr_ctrl & regs.wdata[CTRL_RX_FLUSH];

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(regs.wdata[DW-1:0]), .head(tx_data), .full(tx_full), .empty(tx_empty),
    .count(tx_count)
  );

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .din(rx_data), .head(rx_head), .full(rx_full), .empty(rx_empty),
    .count(rx_count)
  );

  // Sticky error flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      if (wr_txdata && tx_full)                    tx_ovf <= 1'b1;
      else if (wr_status && regs.wdata[ST_TX_OVF]) tx_ovf <= 1'b0;
      if (rd_rxdata && rx_empty)                   rx_udf <= 1'b1;
      else if (wr_status && regs.wdata[ST_RX_UDF]) rx_udf <= 1'b0;
    end
  end

  always_comb begin
    st          = '0;
    st.tx_count = 9'(tx_count);
    st.rx_count = 9'(rx_count);
    st.tx_ovf   = tx_ovf;
    st.rx_udf   = rx_udf;
    st.tx_full  = tx_full;
    st.tx_empty = tx_empty;
    st.rx_full  = rx_full;
    st.rx_empty = rx_empty;
  end

  always_comb begin
    rx_head_ext         = '0;
    rx_head_ext[DW-1:0] = rx_head;
  end

`ifdef REG_FIFO_BANK_IRQ_EN
  logic [2:0] irq_mask;
  logic [2:0] irq_cond;
  logic       irq_q;

  assign irq_cond = {tx_ovf | rx_udf, ~rx_empty, tx_empty};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_mask <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (regs.wr && (regs.waddr == AW'(REG_IRQ_MASK))) irq_mask <= regs.wdata[2:0];
      irq_q <= |(irq_mask & irq_cond);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata_nxt = '0;
    if (regs.raddr == AW'(REG_STATUS)) begin
      rdata_nxt = st;
    end else if (regs.raddr == AW'(REG_RXDATA)) begin
      rdata_nxt = rx_empty ? 32'h0 : rx_head_ext;
    end
`ifdef REG_FIFO_BANK_IRQ_EN
    else if (regs.raddr == AW'(REG_IRQ_MASK)) begin
      rdata_nxt = {29'h0, irq_mask};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs.rdata <= '0;
    else if (regs.rd) regs.rdata <= rdata_nxt;
  end

endmodule
